apb_req_arbiter: RTL and testbench
==================================

// Module: apb_req_arbiter
// PURPOSE
//  Round-robin arbiter and APB master that shares one 8-entry APB register slave between NUM_REQ requesters.
//  Each requester issues single read/write requests over a req/ack handshake.
//  The block sequences each granted request as one APB transfer: SETUP, ACCESS, then a capture cycle.
//  Sits between the requesting engines and the slave's psel/penable/pwrite/addr/pwdata/prdata pins.
// PARAMETERS
//  NUM_REQ    2   number of requesters (>=2)
//  ADDR_W     8   APB address width
//  DATA_W     8   APB data width
//  MEM_DEPTH  8   slave register count; addr >= MEM_DEPTH is rejected without an APB transfer
// PORTS
//  clk        in   1                 clock, all logic on rising edge
//  reset      in   1                 synchronous, active-high
//  req        in   NUM_REQ           per-requester request, held until its ack
//  req_write  in   NUM_REQ           1 = write, 0 = read (per requester)
//  req_addr   in   NUM_REQ*ADDR_W    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   NUM_REQ*DATA_W    packed write data, same packing
//  ack        out  NUM_REQ           one-hot, 1-cycle completion pulse to the granted requester
//  err        out  1                 valid with ack; 1 = address out of range
//  rdata      out  DATA_W            read data, valid with ack on reads
//  busy       out  1                 1 in any state other than IDLE
//  psel       out  1                 APB select
//  penable    out  1                 APB enable
//  pwrite     out  1                 APB direction
//  addr       out  ADDR_W            APB address
//  pwdata     out  DATA_W            APB write data
//  prdata     in   DATA_W            APB read data; slave registers it at the end of ACCESS
// BEHAVIOUR
//  Reset (synchronous, sampled on the clk edge):
//   - All outputs go to 0; state = IDLE.
//   - Round-robin pointer last = NUM_REQ-1, so requester 0 wins first.
//   - Reset mid-transfer: psel/penable are 0 the next cycle; no ack; the request is dropped.
//  State machine, registered outputs:
//   - IDLE: if any req, grant g = first requester with req=1 searching last+1, last+2, ... (mod NUM_REQ).
//     Latch g, req_write[g], req_addr[g], req_wdata[g]. Set last = g.
//     If addr < MEM_DEPTH, go to SETUP; otherwise go to RESP with err=1. No req: stay in IDLE.
//   - SETUP: psel=1, penable=0; addr/pwrite/pwdata carry the latched values. Go to ACCESS.
//   - ACCESS: psel=1, penable=1, same addr/pwrite/pwdata. The slave performs the op at the end of this cycle. Go to CAPTURE.
//   - CAPTURE: psel=0, penable=0. At the end of the cycle, rdata <= prdata on a read; rdata is unchanged on a write. Go to RESP.
//   - RESP: ack[g]=1 for exactly this cycle; err=1 only on the reject path. Go to IDLE.
//  Timing:
//   - Latency: req sampled in IDLE at cycle 0 -> ack at cycle 4 for a transfer, cycle 1 for a reject.
//   - Minimum spacing between transfers: 5 cycles (RESP is always followed by one IDLE cycle).
//  Handshake and bus rules:
//   - Requester holds req and its fields stable until ack.
//   - req still high in the cycle after ack is a new request.
//   - Withdrawing req before ack is illegal; if it happens, the transfer still completes and ack is still issued.
//   - addr/pwrite/pwdata hold their last values while psel=0. penable is never 1 while psel=0.
//   - Exactly one APB transfer per granted in-range request; never two transfers back-to-back without psel=0 between them.
//   - Simultaneous requests: one grant per arbitration. The winner becomes lowest priority next time, so no requester starves.
//   - Requests arriving outside IDLE are not seen until the next IDLE cycle.
// TESTING
//  1. Reset, then req[0] write addr=3 wdata=0xA5.
//     -> SETUP at cyc1 (psel=1, pen=0), ACCESS at cyc2 (pen=1, pwrite=1, addr=3, pwdata=0xA5), ack[0] at cyc4 with err=0; slave mem[3]=0xA5.
//  2. req[1] read addr=3 after test 1.
//     -> pwrite=0 in ACCESS, ack[1] with rdata=0xA5, err=0.
//  3. req[0] and req[1] both held continuously after reset.
//     -> grants alternate 0,1,0,1; acks 5 cycles apart; no psel gap shorter than 3 cycles.
//  4. req[1] read addr=9 (MEM_DEPTH=8).
//     -> no psel; ack[1] with err=1 at cycle 1; slave contents unchanged.
//  5. Assert reset during ACCESS of a write to addr=2.
//     -> psel=penable=0 next cycle, no ack, all outputs 0, pointer reset so req[0] wins next.
//  6. req[0] write addr=7 wdata=0xFF, then read addr=0 immediately after ack.
//     -> wrap-edge addr 7 accepted; read of addr 0 returns 0 (slave reset value).

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// Requester handshake and APB pin bundle for apb_req_arbiter.
// The master modport is the arbiter's view; the slave modport is the requesters' and APB slave's view.
interface apb_req_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        ack;
    logic                      err;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_W-1:0]         addr;
    logic [DATA_W-1:0]         pwdata;
    logic [DATA_W-1:0]         prdata;

    modport master (
        input  req, req_write, req_addr, req_wdata, prdata,
        output ack, err, rdata, busy, psel, penable, pwrite, addr, pwdata
    );

    modport slave (
        output req, req_write, req_addr, req_wdata, prdata,
        input  ack, err, rdata, busy, psel, penable, pwrite, addr, pwdata
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that turns single requester transactions into APB transfers
// on one shared register slave; out-of-range addresses are answered with err and no transfer.
//
// state     | meaning
// S_IDLE    | waiting for any req; arbitrate and latch the winner
// S_SETUP   | APB setup phase (psel=1, penable=0)
// S_ACCESS  | APB access phase (psel=1, penable=1); slave acts at the end
// S_CAPTURE | bus idle; prdata captured into rdata on reads
// S_RESP    | one-cycle ack to the granted requester (err on reject)
module apb_req_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 8
) (
    input logic i_clk,
    input logic i_reset,
    apb_req_arbiter_if.master bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_last, w_last_nxt;
    logic [PTR_W-1:0]   r_gnt, w_gnt_nxt;
    logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
    logic               r_err, w_err_nxt;
    logic [DATA_W-1:0]  r_rdata, w_rdata_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_psel, w_psel_nxt;
    logic               r_penable, w_penable_nxt;
    logic               r_pwrite, w_pwrite_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [DATA_W-1:0]  r_pwdata, w_pwdata_nxt;

    logic               w_found;
    logic [PTR_W-1:0]   w_sel;
    int                 w_idx;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_sel_write;
    logic               w_in_range;

    // Search starts just after the last winner so it becomes lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        w_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = int'(r_last) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = PTR_W'(w_idx);
            end
        end
    end

    assign w_sel_addr  = bus.req_addr[int'(w_sel)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = bus.req_wdata[int'(w_sel)*DATA_W +: DATA_W];
    assign w_sel_write = bus.req_write[w_sel];
    assign w_in_range  = (int'(w_sel_addr) < MEM_DEPTH);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_last    <= PTR_W'(NUM_REQ - 1);
            r_gnt     <= '0;
            r_ack     <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_busy    <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_addr    <= '0;
            r_pwdata  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_gnt     <= w_gnt_nxt;
            r_ack     <= w_ack_nxt;
            r_err     <= w_err_nxt;
            r_rdata   <= w_rdata_nxt;
            r_busy    <= w_busy_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_addr    <= w_addr_nxt;
            r_pwdata  <= w_pwdata_nxt;
        end
    end

    // Outputs are registered, so each branch sets the values for the state being entered.
    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_gnt_nxt     = r_gnt;
        w_ack_nxt     = '0;
        w_err_nxt     = 1'b0;
        w_rdata_nxt   = r_rdata;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_pwrite_nxt  = r_pwrite;
        w_addr_nxt    = r_addr;
        w_pwdata_nxt  = r_pwdata;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt  = w_sel;
                    w_last_nxt = w_sel;
                    if (w_in_range) begin
                        w_state_nxt  = S_SETUP;
                        w_psel_nxt   = 1'b1;
                        w_pwrite_nxt = w_sel_write;
                        w_addr_nxt   = w_sel_addr;
                        w_pwdata_nxt = w_sel_wdata;
                    end else begin
                        // Bus pins keep their old values on a reject.
                        w_state_nxt = S_RESP;
                        w_ack_nxt   = NUM_REQ'(1) << w_sel;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                w_state_nxt   = S_ACCESS;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end
            S_ACCESS: begin
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_nxt = S_RESP;
                w_ack_nxt   = NUM_REQ'(1) << r_gnt;
                if (!r_pwrite) w_rdata_nxt = bus.prdata;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign bus.ack     = r_ack;
    assign bus.err     = r_err;
    assign bus.rdata   = r_rdata;
    assign bus.busy    = r_busy;
    assign bus.psel    = r_psel;
    assign bus.penable = r_penable;
    assign bus.pwrite  = r_pwrite;
    assign bus.addr    = r_addr;
    assign bus.pwdata  = r_pwdata;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: vector table of single transactions plus
// hand-written sequences for contention and reset during ACCESS, against a small APB slave model.
module tb_apb_req_arbiter;
    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;

    logic clk;
    logic reset;

    apb_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_req_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(8)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // APB register slave: acts at the end of ACCESS, prdata registered.
    logic [7:0] mem [0:7];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
            bus.prdata <= 8'h00;
        end else if (bus.psel && bus.penable) begin
            if (bus.pwrite) mem[bus.addr[2:0]] <= bus.pwdata;
            else            bus.prdata <= mem[bus.addr[2:0]];
        end
    end

    int viol;
    initial viol = 0;
    always @(negedge clk) begin
        if (!reset && bus.penable && !bus.psel) viol++;
    end

    int n_pass;
    int n_total;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    typedef struct {
        int         id;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       exp_err;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    vec_t vecs [10];

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int  lat;
        int  nsel;
        bit  got;
        bus.req_write[v.id]           = v.wr;
        bus.req_addr[v.id*8 +: 8]     = v.addr;
        bus.req_wdata[v.id*8 +: 8]    = v.wdata;
        bus.req[v.id]                 = 1'b1;
        check($sformatf("v%0d_busy_idle", n), 32'(bus.busy), 32'd0);
        lat  = 0;
        nsel = 0;
        got  = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(posedge clk);
            #1;
            if (bus.psel) nsel++;
            if (c == 1 && !v.exp_err)
                check($sformatf("v%0d_setup", n), 32'({bus.psel, bus.penable}), 32'b10);
            if (bus.psel && bus.penable) begin
                check($sformatf("v%0d_acc_cyc", n), 32'(c), 32'd2);
                check($sformatf("v%0d_acc_pwrite", n), 32'(bus.pwrite), 32'(v.wr));
                check($sformatf("v%0d_acc_addr", n), 32'(bus.addr), 32'(v.addr));
                if (v.wr) check($sformatf("v%0d_acc_pwdata", n), 32'(bus.pwdata), 32'(v.wdata));
            end
            if (bus.ack != '0) begin
                got = 1'b1;
                lat = c;
            end
        end
        check($sformatf("v%0d_ack_seen", n), 32'(got), 32'd1);
        check($sformatf("v%0d_latency", n), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d_ack_onehot", n), 32'(bus.ack), 32'd1 << v.id);
        check($sformatf("v%0d_err", n), 32'(bus.err), 32'(v.exp_err));
        check($sformatf("v%0d_rdata", n), 32'(bus.rdata), 32'(v.exp_rdata));
        check($sformatf("v%0d_psel_cycles", n), 32'(nsel), v.exp_err ? 32'd0 : 32'd2);
        bus.req[v.id] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic int ack_id(input logic [NUM_REQ-1:0] a);
        if (a == 2'b01) return 0;
        if (a == 2'b10) return 1;
        return 99;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  ids  [4];
        int  cycs [4];
        int  nack;
        int  low_run;
        bit  seen_fall;
        bit  prev_psel;
        bit  got;
        int  lat;

        n_pass  = 0;
        n_total = 0;
        bus.req       = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        //          id wr addr   wdata  err rdata lat
        vecs[0] = '{0, 1, 8'd3,  8'hA5, 0, 8'h00, 4};
        vecs[1] = '{1, 0, 8'd3,  8'h00, 0, 8'hA5, 4};
        vecs[2] = '{1, 0, 8'd9,  8'h00, 1, 8'hA5, 1};
        vecs[3] = '{0, 0, 8'd3,  8'h00, 0, 8'hA5, 4};
        vecs[4] = '{0, 1, 8'd7,  8'hFF, 0, 8'hA5, 4};
        vecs[5] = '{0, 0, 8'd0,  8'h00, 0, 8'h00, 4};
        vecs[6] = '{1, 0, 8'd7,  8'h00, 0, 8'hFF, 4};
        vecs[7] = '{0, 1, 8'd8,  8'h5A, 1, 8'hFF, 1};
        vecs[8] = '{1, 1, 8'd6,  8'h3C, 0, 8'hFF, 4};
        vecs[9] = '{0, 0, 8'd6,  8'h00, 0, 8'h3C, 4};

        do_reset();
        check("rst_ack_err_busy", 32'({bus.ack, bus.err, bus.busy}), 32'd0);
        check("rst_psel_pen_pwrite", 32'({bus.psel, bus.penable, bus.pwrite}), 32'd0);
        check("rst_addr_pwdata_rdata", 32'({bus.addr, bus.pwdata, bus.rdata}), 32'd0);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Contention: both requesters held continuously from reset.
        do_reset();
        bus.req_write = 2'b11;
        bus.req_addr  = {8'd2, 8'd1};
        bus.req_wdata = {8'h22, 8'h11};
        bus.req       = 2'b11;
        nack      = 0;
        low_run   = 0;
        seen_fall = 1'b0;
        prev_psel = 1'b0;
        for (int c = 1; c <= 60 && nack < 4; c++) begin
            @(posedge clk);
            #1;
            if (bus.psel && !prev_psel && seen_fall)
                check("rr_psel_gap", 32'(low_run), 32'd3);
            if (!bus.psel && prev_psel) begin
                seen_fall = 1'b1;
                low_run   = 0;
            end
            if (!bus.psel) low_run++;
            prev_psel = bus.psel;
            if (bus.ack != '0) begin
                ids[nack]  = ack_id(bus.ack);
                cycs[nack] = c;
                nack++;
            end
        end
        bus.req = '0;
        check("rr_ack_count", 32'(nack), 32'd4);
        if (nack == 4) begin
            check("rr_first_lat", 32'(cycs[0]), 32'd4);
            for (int k = 0; k < 4; k++)
                check($sformatf("rr_grant%0d", k), 32'(ids[k]), 32'(k % 2));
            for (int k = 1; k < 4; k++)
                check($sformatf("rr_spacing%0d", k), 32'(cycs[k] - cycs[k-1]), 32'd5);
        end
        repeat (2) @(posedge clk);
        #1;
        check("rr_mem1", 32'(mem[1]), 32'h11);
        check("rr_mem2", 32'(mem[2]), 32'h22);

        // Reset during ACCESS of a write by requester 0.
        bus.req_write[0]   = 1'b1;
        bus.req_addr[7:0]  = 8'd2;
        bus.req_wdata[7:0] = 8'h77;
        bus.req[0]         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mr_in_access", 32'({bus.psel, bus.penable}), 32'b11);
        reset = 1'b1;
        bus.req_write[1]    = 1'b1;
        bus.req_addr[15:8]  = 8'd4;
        bus.req_wdata[15:8] = 8'h44;
        bus.req             = 2'b11;
        @(posedge clk);
        #1;
        check("mr_bus_idle", 32'({bus.psel, bus.penable}), 32'd0);
        check("mr_no_ack", 32'({bus.ack, bus.err, bus.busy}), 32'd0);
        check("mr_outs_zero", 32'({bus.pwrite, bus.addr, bus.pwdata, bus.rdata}), 32'd0);
        reset = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(posedge clk);
            #1;
            if (bus.ack != '0) begin
                got = 1'b1;
                lat = c;
            end
        end
        check("mr_ack_seen", 32'(got), 32'd1);
        check("mr_first_winner", 32'(bus.ack), 32'b01);
        check("mr_latency", 32'(lat), 32'd4);
        bus.req = '0;
        repeat (3) @(posedge clk);
        #1;
        check("mr_busy_after", 32'(bus.busy), 32'd0);
        check("pen_without_psel", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
